// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM read/write arbiter: FSM state encoding,
// default bus widths, the bit positions of the call/done vectors and the
// round-robin pick helper.
// Optional feature macro used by the arbiter: SDRAM_ARB_WDOG_EN.
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  // Bank(2) + Row(13) + Column(9)
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  // Bit positions inside sd_call / sd_done
  localparam int CALL_WR = 1;
  localparam int CALL_RD = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_RD = 2'd1,
    ST_GRANT_WR = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  // Read wins when it is the only requester, or on a tie when write was
  // granted last. Caller guarantees at least one request is high.
  function automatic logic pick_read(input logic rd_req,
                                     input logic wr_req,
                                     input logic last_wr);
    return rd_req && (!wr_req || last_wr);
  endfunction

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter_if
// Bundles the requester side (draw-stage write, TFT-refresh read), the
// controller side (sd_*) and the status signals of the arbiter.
//   slave  : the arbiter's view (takes requests, drives the controller)
//   master : the environment's view (requesters + controller)
// Signals: en, rd_req/rd_addr/rd_data/rd_done, wr_req/wr_addr/wr_data/wr_done,
//          sd_call/sd_addr/sd_wdata/sd_rdata/sd_done, timeout_err.
// ---------------------------------------------------------------------------
interface sdram_rw_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              en;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic [1:0]        sd_call;
  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_wdata;
  logic [DATA_W-1:0] sd_rdata;
  logic [1:0]        sd_done;
  logic              timeout_err;

  modport slave (
    input  en, rd_req, rd_addr, wr_req, wr_addr, wr_data, sd_rdata, sd_done,
    output rd_data, rd_done, wr_done, sd_call, sd_addr, sd_wdata, timeout_err
  );

  modport master (
    output en, rd_req, rd_addr, wr_req, wr_addr, wr_data, sd_rdata, sd_done,
    input  rd_data, rd_done, wr_done, sd_call, sd_addr, sd_wdata, timeout_err
  );
endinterface

// File: rtl/sdram_arb_wdog.sv
// ---------------------------------------------------------------------------
// sdram_arb_wdog
// Access watchdog: cleared by load, advanced by count, and flags expired in
// the cycle where the current grant has lasted TIMEOUT_CYCLES cycles, so the
// arbiter's registered abort lands exactly TIMEOUT_CYCLES after the grant.
// Ports: clk, rst_n (async, active low), load, count -> expired (comb).
// Only instantiated when SDRAM_ARB_WDOG_EN is defined.
// ---------------------------------------------------------------------------
module sdram_arb_wdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter is 0 on the grant edge, so reaching TIMEOUT_CYCLES-1 means
  // the next edge is TIMEOUT_CYCLES cycles after the grant.
  assign expired = count && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sdram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter
// Round-robin arbiter placing the draw stage (writes) and the TFT refresh
// stage (reads) on the single SDRAM controller port. Both sides and the
// controller use a level-request / one-cycle-done handshake.
// Ports: clk, rst_n (async, active low), bus (sdram_rw_arbiter_if.slave).
// All bus outputs are registered.
// Optional feature: define SDRAM_ARB_WDOG_EN to abort a grant that sees no
// matching sd_done within TIMEOUT_CYCLES (pulses timeout_err with *_done).
// ---------------------------------------------------------------------------
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst_n,
  sdram_rw_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic [1:0]        sd_call_q, sd_call_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0] sd_wdata_q, sd_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              timeout_q, timeout_d;
  logic              last_wr_q, last_wr_d;   // 1: write was granted last
  logic              wdog_expired;

`ifdef SDRAM_ARB_WDOG_EN
  logic wdog_load;
  logic wdog_count;

  assign wdog_load  = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign wdog_count = (state_q == ST_GRANT_RD) || (state_q == ST_GRANT_WR);

  sdram_arb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wdog_load),
    .count  (wdog_count),
    .expired(wdog_expired)
  );
`else
  // No watchdog: a grant waits for its sd_done indefinitely.
  assign wdog_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    sd_call_d  = sd_call_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    rd_data_d  = rd_data_q;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;
    timeout_d  = 1'b0;
    last_wr_d  = last_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.rd_req || bus.wr_req)) begin
          sd_call_d = '0;
          if (pick_read(bus.rd_req, bus.wr_req, last_wr_q)) begin
            sd_call_d[CALL_RD] = 1'b1;
            sd_addr_d          = bus.rd_addr;
            state_d            = ST_GRANT_RD;
          end else begin
            sd_call_d[CALL_WR] = 1'b1;
            sd_addr_d          = bus.wr_addr;
            sd_wdata_d         = bus.wr_data;
            state_d            = ST_GRANT_WR;
          end
        end
      end

      // A done bit for the other side is a stray and is ignored. A real
      // done takes priority over a watchdog expiry in the same cycle.
      ST_GRANT_RD: begin
        if (bus.sd_done[CALL_RD] || wdog_expired) begin
          sd_call_d = '0;
          rd_done_d = 1'b1;
          if (bus.sd_done[CALL_RD]) begin
            rd_data_d = bus.sd_rdata;
          end else begin
            timeout_d = 1'b1;
          end
          last_wr_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end

      ST_GRANT_WR: begin
        if (bus.sd_done[CALL_WR] || wdog_expired) begin
          sd_call_d = '0;
          wr_done_d = 1'b1;
          timeout_d = !bus.sd_done[CALL_WR];
          last_wr_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end

      // The finished requester still holds req during its done cycle;
      // sitting out one cycle keeps it from being granted a second time.
      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sd_call_q  <= '0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
      last_wr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      sd_call_q  <= sd_call_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
      timeout_q  <= timeout_d;
      last_wr_q  <= last_wr_d;
    end
  end

  assign bus.sd_call     = sd_call_q;
  assign bus.sd_addr     = sd_addr_q;
  assign bus.sd_wdata    = sd_wdata_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_rw_arbiter
// Directed bench for sdram_rw_arbiter: a table of single accesses with
// hand-computed grants, then sequences for en gating, reset mid-write with
// round-robin alternation, a stray done, and (with SDRAM_ARB_WDOG_EN) the
// watchdog abort at TIMEOUT_CYCLES = 16.
// ---------------------------------------------------------------------------
module tb_sdram_rw_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sdram_rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_rw_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // controller model knobs
  int          ctl_lat   = 10;
  logic        ctl_mute  = 1'b0;
  logic [15:0] ctl_rdata = 16'h0;
  logic [1:0]  stray     = 2'b00;

  typedef struct {
    logic        rd_req;
    logic        wr_req;
    logic [23:0] rd_addr;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rdata;
    int          lat;
    logic [1:0]  exp_call;
    logic [23:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rd_data;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller: answers a call after ctl_lat cycles; stray bits are OR'd in.
  initial begin : ctl_model
    int busy;
    busy = 0;
    bus.sd_done  = 2'b00;
    bus.sd_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.sd_done = stray;
      stray = 2'b00;
      if (bus.sd_call != 2'b00 && !ctl_mute) begin
        if (busy >= ctl_lat - 1) begin
          bus.sd_done  = bus.sd_done | bus.sd_call;
          bus.sd_rdata = ctl_rdata;
          busy = 0;
        end else begin
          busy++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic wait_call(input string name, input logic [1:0] exp_call, input logic [23:0] exp_addr);
    int i;
    i = 0;
    while (bus.sd_call == 2'b00 && i < 100) begin
      tick();
      i++;
    end
    chk({name, "_call"}, 32'(bus.sd_call), 32'(exp_call));
    chk({name, "_addr"}, 32'(bus.sd_addr), 32'(exp_addr));
  endtask

  // Waits for the done pulse; checks side, no wrong-side pulse, call held.
  task automatic wait_done(input string name, input logic exp_rd, input int bound, output int cyc);
    logic [1:0] call0;
    int         wrong;
    logic       held;
    logic       seen;
    logic       right;
    call0 = bus.sd_call;
    wrong = 0; held = 1'b1; seen = 1'b0; right = 1'b0; cyc = 0;
    while (!seen && cyc < bound) begin
      tick();
      cyc++;
      if (exp_rd ? bus.wr_done : bus.rd_done) wrong++;
      if (bus.rd_done || bus.wr_done) begin
        seen  = 1'b1;
        right = exp_rd ? bus.rd_done : bus.wr_done;
      end else if (bus.sd_call !== call0) begin
        held = 1'b0;
      end
    end
    chk({name, "_done"}, 32'(right), 32'd1);
    chk({name, "_other_done"}, 32'(wrong), 32'd0);
    chk({name, "_call_held"}, 32'(held), 32'd1);
    chk({name, "_call_off"}, 32'(bus.sd_call), 32'd0);
  endtask

  initial begin : watchdog_guard
    #500000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int   cyc;
    int   calls;
    logic exp_rd;

    vecs[0] = '{1'b1, 1'b0, 24'h012345, 24'h000000, 16'h0000, 16'hBEEF, 10, 2'b01, 24'h012345, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'h0A0001, 16'h1234, 16'h0000, 3,  2'b10, 24'h0A0001, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 24'h000100, 24'h000200, 16'h5678, 16'hCAFE, 2,  2'b01, 24'h000100, 16'h1234, 16'hCAFE};
    vecs[3] = '{1'b0, 1'b1, 24'h000000, 24'h000200, 16'h5678, 16'h0000, 1,  2'b10, 24'h000200, 16'h5678, 16'hCAFE};
    vecs[4] = '{1'b1, 1'b0, 24'h000300, 24'h000000, 16'h0000, 16'h1111, 4,  2'b01, 24'h000300, 16'h5678, 16'h1111};
    vecs[5] = '{1'b1, 1'b1, 24'h000400, 24'h000500, 16'h9ABC, 16'h2222, 2,  2'b10, 24'h000500, 16'h9ABC, 16'h1111};
    vecs[6] = '{1'b1, 1'b0, 24'h000400, 24'h000000, 16'h0000, 16'h2222, 1,  2'b01, 24'h000400, 16'h9ABC, 16'h2222};

    bus.en = 1'b1; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_sd_call", 32'(bus.sd_call), 32'd0);
    chk("rst_sd_addr", 32'(bus.sd_addr), 32'd0);
    chk("rst_sd_wdata", 32'(bus.sd_wdata), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_done", 32'(bus.rd_done), 32'd0);
    chk("rst_wr_done", 32'(bus.wr_done), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- table of single accesses ----
    for (int v = 0; v < 7; v++) begin
      ctl_lat     = vecs[v].lat;
      ctl_rdata   = vecs[v].rdata;
      bus.rd_req  = vecs[v].rd_req;
      bus.wr_req  = vecs[v].wr_req;
      bus.rd_addr = vecs[v].rd_addr;
      bus.wr_addr = vecs[v].wr_addr;
      bus.wr_data = vecs[v].wr_data;
      wait_call($sformatf("v%0d", v), vecs[v].exp_call, vecs[v].exp_addr);
      chk($sformatf("v%0d_wdata", v), 32'(bus.sd_wdata), 32'(vecs[v].exp_wdata));
      exp_rd = (vecs[v].exp_call == 2'b01);
      wait_done($sformatf("v%0d", v), exp_rd, 40, cyc);
      chk($sformatf("v%0d_rd_data", v), 32'(bus.rd_data), 32'(vecs[v].exp_rd_data));
      chk($sformatf("v%0d_timeout", v), 32'(bus.timeout_err), 32'd0);
      $display("vec %0d: call=%b addr=%h wdata=%h rd_data=%h", v, vecs[v].exp_call,
               vecs[v].exp_addr, vecs[v].exp_wdata, bus.rd_data);
      if (exp_rd) bus.rd_req = 1'b0;
      else        bus.wr_req = 1'b0;
      tick();
      chk($sformatf("v%0d_done_pulse", v), 32'(bus.rd_done | bus.wr_done), 32'd0);
      tick();
    end

    // ---- en low during an active write ----
    ctl_lat = 5;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h0D0000; bus.wr_data = 16'hA5A5;
    wait_call("en_wr", 2'b10, 24'h0D0000);
    bus.en = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h0E0000;
    wait_done("en_wr", 1'b0, 40, cyc);
    bus.wr_req = 1'b0;
    calls = 0;
    repeat (10) begin
      tick();
      if (bus.sd_call != 2'b00) calls++;
    end
    chk("en_low_no_call", 32'(calls), 32'd0);
    $display("en test: write completed, %0d calls while en low", calls);
    bus.en = 1'b1; ctl_lat = 2; ctl_rdata = 16'h0E0E;
    wait_call("en_rd", 2'b01, 24'h0E0000);
    wait_done("en_rd", 1'b1, 40, cyc);
    chk("en_rd_data", 32'(bus.rd_data), 32'h0E0E);
    bus.rd_req = 1'b0;
    tick(); tick();

    // ---- reset in the middle of GRANT_WR, then round-robin R,W,R,W ----
    ctl_lat = 30;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h0B0B0B; bus.wr_data = 16'h7777;
    wait_call("rst_wr", 2'b10, 24'h0B0B0B);
    tick(); tick();
    bus.rd_req = 1'b1; bus.rd_addr = 24'h0C0C0C;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_sd_call", 32'(bus.sd_call), 32'd0);
    chk("midrst_done", 32'({bus.rd_done, bus.wr_done}), 32'd0);
    chk("midrst_sd_addr", 32'(bus.sd_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    ctl_lat = 3; ctl_rdata = 16'h5A5A;
    for (int k = 0; k < 4; k++) begin
      exp_rd = (k % 2 == 0);
      wait_call($sformatf("rr%0d", k), exp_rd ? 2'b01 : 2'b10, exp_rd ? 24'h0C0C0C : 24'h0B0B0B);
      wait_done($sformatf("rr%0d", k), exp_rd, 40, cyc);
      $display("rr access %0d: %s", k, exp_rd ? "read" : "write");
      if (k == 3) begin
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        tick(); tick();
      end else begin
        tick();
        chk($sformatf("rr%0d_gap1", k), 32'(bus.sd_call), 32'd0);
        tick();
        chk($sformatf("rr%0d_gap2", k), 32'(bus.sd_call != 2'b00), 32'd1);
      end
    end
    chk("rr_rd_data", 32'(bus.rd_data), 32'h5A5A);

    // ---- stray write-done during a read grant ----
    ctl_lat = 8; ctl_rdata = 16'h4242;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000777;
    wait_call("stray", 2'b01, 24'h000777);
    tick();
    stray = 2'b10;
    wait_done("stray", 1'b1, 40, cyc);
    chk("stray_rd_data", 32'(bus.rd_data), 32'h4242);
    $display("stray test: read finished after %0d cycles", cyc);
    bus.rd_req = 1'b0;
    tick(); tick();

`ifdef SDRAM_ARB_WDOG_EN
    // ---- watchdog: controller never answers the read ----
    ctl_mute = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000888;
    wait_call("wd_rd", 2'b01, 24'h000888);
    bus.wr_req = 1'b1; bus.wr_addr = 24'h000999; bus.wr_data = 16'h3C3C;
    wait_done("wd_rd", 1'b1, 40, cyc);
    chk("wd_latency", 32'(cyc), 32'd16);
    chk("wd_timeout_err", 32'(bus.timeout_err), 32'd1);
    chk("wd_rd_data", 32'(bus.rd_data), 32'h4242);
    $display("watchdog test: abort after %0d cycles", cyc);
    bus.rd_req = 1'b0; ctl_mute = 1'b0; ctl_lat = 2;
    wait_call("wd_wr", 2'b10, 24'h000999);
    wait_done("wd_wr", 1'b0, 40, cyc);
    chk("wd_wr_timeout_err", 32'(bus.timeout_err), 32'd0);
    bus.wr_req = 1'b0;
    tick(); tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sdram_rw_arbiter.md
# sdram_rw_arbiter

- Arbitrates the single SDRAM port between two requesters:
  - The draw stage, which writes pixels.
  - The TFT refresh stage, which reads pixels.
- Sits directly upstream of the SDRAM base controller and presents exactly one `call`/`addr`/`data` set to it.
- Uses the same level-request / done-pulse handshake as the controller, so the upstream stages connect unchanged.
- Alternates grants round-robin so that neither display refresh nor drawing starves.

## Interface
- `ADDR_W`, 24, SDRAM address width: Bank(2)+Row(13)+Column(9).
- `DATA_W`, 16, SDRAM data width.
- `TIMEOUT_CYCLES`, 4096, watchdog limit in `clk` cycles (used only with `SDRAM_ARB_WDOG_EN`).
- `clk`  in  1  system clock (133 MHz SDRAM-domain clock).
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  when low, no new grant is issued; an in-flight access completes.
- `rd_req`  in  1  read request; level, held until `rd_done`.
- `rd_addr`  in  ADDR_W  read address; stable while `rd_req` is high.
- `rd_data`  out  DATA_W  read data, valid in the `rd_done` cycle and held afterwards.
- `rd_done`  out  1  one-cycle pulse: read finished.
- `wr_req`  in  1  write request; level, held until `wr_done`.
- `wr_addr`  in  ADDR_W  write address; stable while `wr_req` is high.
- `wr_data`  in  DATA_W  write data; stable while `wr_req` is high.
- `wr_done`  out  1  one-cycle pulse: write finished.
- `sd_call`  out  2  to controller: [1] write, [0] read; at most one bit set.
- `sd_addr`  out  ADDR_W  to controller address.
- `sd_wdata`  out  DATA_W  to controller write data.
- `sd_rdata`  in  DATA_W  from controller read data.
- `sd_done`  in  2  from controller: [1] write done, [0] read done; one-cycle pulses.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts an access.

## Operation
- **States:** IDLE, GRANT_RD, GRANT_WR, RELEASE.
- **IDLE, grant conditions:** a grant is issued only if `en` is high and at least one request is high.
  - Only one requester high: it wins.
  - Both high: the side not granted last wins (round-robin).
  - The `last` flag resets to "write", so read wins the first tie.
- **IDLE, on a grant:**
  - Latch the winner's address, and its data for writes, into `sd_addr` / `sd_wdata`.
  - Set the matching `sd_call` bit.
  - Go to GRANT_RD or GRANT_WR.
- **GRANT_x:** hold `sd_call`, `sd_addr` and `sd_wdata` constant until the matching `sd_done` bit arrives. On that cycle:
  - Clear `sd_call`.
  - Pulse `rd_done` or `wr_done`; for reads, register `sd_rdata` into `rd_data`.
  - Update `last`.
  - Go to RELEASE.
- **Stray done:** an `sd_done` bit that does not match the current grant is ignored.
- **RELEASE:** one cycle, no grant. It absorbs the requester's `req`, which is still high during its done cycle. Then return to IDLE.
- **`en` low:** has no effect in GRANT_x or RELEASE.
- **Reset:** asserting `rst_n` mid-access immediately clears all outputs; the state returns to IDLE.
- **Reset values:**
  - `sd_call`, `rd_done`, `wr_done`, `timeout_err`: 0.
  - `sd_addr`, `sd_wdata`, `rd_data`: 0.
  - `last`: write.

## Timing
- **Grant latency:** a request seen high in IDLE at edge N gives `sd_call` high from edge N+1.
- **Completion:** `sd_done` at edge M gives `*_done` and `sd_call` = 0 at edge M+1, RELEASE at M+1, and IDLE at M+2.
- **Next grant:** the earliest back-to-back grant sets `sd_call` at M+3.
- **Throughput:** minimum arbitration overhead is 3 cycles per access beyond controller latency.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **`SDRAM_ARB_WDOG_EN` defined:**
  - A counter runs in GRANT_x.
  - At `TIMEOUT_CYCLES` without a matching `sd_done`, the arbiter:
    - clears `sd_call`,
    - pulses `timeout_err` together with the granted side's `*_done` (`rd_data` unchanged),
    - goes to RELEASE and updates `last`.
  - The counter clears on every grant.
- **Undefined:** `timeout_err` is tied to 0, no counter is built, and GRANT_x waits indefinitely.

## Structure
- **Package `sdram_arb_pkg`:**
  - State enum.
  - `ADDR_W` and `DATA_W` defaults.
  - Call-bit indices `CALL_WR` = 1 and `CALL_RD` = 0.
- **Sub-module `sdram_arb_wdog`:**
  - Load/count/expire counter.
  - Instantiated only under `SDRAM_ARB_WDOG_EN`.

## Test plan
- Single read: `rd_req` with `rd_addr` = 24'h012345; controller model returns 16'hBEEF after 10 cycles -> `sd_call` = 2'b01, `sd_addr` = 24'h012345, `rd_data` = 16'hBEEF with a one-cycle `rd_done`; `wr_done` never pulses.
- Simultaneous `rd_req` + `wr_req` held for 4 accesses -> grants alternate R, W, R, W; gap between `*_done` and the next `sd_call` is 2 cycles.
- `en` = 0 during an active write -> the write completes (`wr_done` pulses) and no further `sd_call` appears until `en` = 1.
- `rst_n` low for 1 cycle in the middle of GRANT_WR -> `sd_call` = 0 and all `*_done` = 0 immediately; after release, a pending `rd_req` is granted first.
- With `SDRAM_ARB_WDOG_EN`, `TIMEOUT_CYCLES` = 16, controller never answers a read -> `sd_call` drops, and `timeout_err` and `rd_done` pulse together 16 cycles after the grant; a pending write is granted next.
- Spurious `sd_done[1]` during GRANT_RD -> ignored; the state stays GRANT_RD and `wr_done` does not pulse.
